muldiv_seq: RTL

- Multi-cycle sequencer for the RV32M multiply/divide operations in the execute stage.
- Captures the two ALU operands (rs1 value, rs2 value) on a start request, then iterates a shift-add multiplier or restoring divider for XLEN cycles.
- Presents the result with a one-cycle done pulse and holds `stall` so the core freezes PC and writeback until completion.
- Sits beside the ALU; the decoder raises `start` for OP-opcode instructions with funct7=0000001.

---
 rtl/muldiv_seq.sv | 104 ++++++++++
 1 files changed

// File: rtl/muldiv_seq.sv
// muldiv_seq: multi-cycle RV32M multiply/divide sequencer (shift-add / restoring).
// Optional MULDIV_EARLY_OUT_EN: skip iteration when either operand is zero.
module muldiv_seq #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            busy,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result
);
  typedef enum logic [2:0] {IDLE, PREP, CALC, FIX, DONE} state_t;
  state_t state;
  logic [2:0] f3;
  logic [XLEN-1:0] a, b, m, abs_a, abs_b, q, r, res;
  logic [2*XLEN-1:0] acc, prod, mul_step, div_step;
  logic [XLEN:0] hi, sh, diff;
  logic [CNT_W-1:0] cnt;
  logic neg_a, neg_b, is_div, sgn_a, sgn_b;
  assign stall = busy | (start & ~flush & (state == IDLE | state == DONE));
  always_comb begin
    is_div = f3[2];
    sgn_a = a[XLEN-1] & (is_div ? ~f3[0] : f3[1:0] != 2'b11);
    sgn_b = b[XLEN-1] & (is_div ? ~f3[0] : ~f3[1]);
    abs_a = sgn_a ? -a : a;
    abs_b = sgn_b ? -b : b;
    hi = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, m} : '0);
    mul_step = {hi, acc[XLEN-1:1]};
    // remainder lives in the upper half, dividend/quotient shifts through the lower half
    sh = acc[2*XLEN-1:XLEN-1];
    diff = sh - {1'b0, m};
    div_step = diff[XLEN] ? {sh[XLEN-1:0], acc[XLEN-2:0], 1'b0} : {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    prod = (neg_a ^ neg_b) ? -acc : acc;
    q = (b == '0) ? '1 : (neg_a ^ neg_b) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    r = (b == '0) ? a : neg_a ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    res = is_div ? (f3[1] ? r : q) : (f3[1:0] == 2'b00 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      result <= '0;
      f3 <= '0;
      a <= '0;
      b <= '0;
      m <= '0;
      acc <= '0;
      cnt <= '0;
      neg_a <= 1'b0;
      neg_b <= 1'b0;
    end else if (flush) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          state <= start ? PREP : IDLE;
          busy <= start;
          if (start) begin
            f3 <= funct3;
            a <= op_a;
            b <= op_b;
          end
        end
        PREP: begin
          neg_a <= sgn_a;
          neg_b <= sgn_b;
          m <= is_div ? abs_b : abs_a;
          acc <= {{XLEN{1'b0}}, is_div ? abs_a : abs_b};
          cnt <= '0;
          state <= CALC;
`ifdef MULDIV_EARLY_OUT_EN
          if (a == '0 || b == '0) begin
            acc <= '0;
            state <= FIX;
          end
`endif
        end
        CALC: begin
          acc <= is_div ? div_step : mul_step;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(XLEN - 1)) state <= FIX;
        end
        FIX: begin
          result <= res;
          busy <= 1'b0;
          done <= 1'b1;
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
